// File: rtl/key_conditioner.sv
// key_conditioner: synchronise and debounce buttons/switches, emit clean levels and one-cycle events; long-press detection built only when KEY_LONG_PRESS_EN is defined
module key_conditioner #(
  parameter int N_BTN       = 2,
  parameter int N_SW        = 8,
  parameter int DB_CYCLES   = 20000,
  parameter int LONG_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_change
);
  localparam int N = N_BTN + N_SW;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES - 1);
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [N_BTN-1:0] long_q, long_d;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif
  logic [N-1:0]     sync1_q, sync2_q, lvl_q, lvl_d, acc;
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];
  logic [N_BTN-1:0] rise, fall, press_q, press_d, rel_q, rel_d;
  logic             chg_q, chg_d;
  state_t           st_q [N_BTN];
  state_t           st_d [N_BTN];

  assign rise = acc[N_BTN-1:0] & sync2_q[N_BTN-1:0];
  assign fall = acc[N_BTN-1:0] & ~sync2_q[N_BTN-1:0];
  assign chg_d = |acc[N-1:N_BTN];
  assign btn_level = lvl_q[N_BTN-1:0];
  assign sw_level = lvl_q[N-1:N_BTN];
  assign btn_press = press_q;
  assign btn_release = rel_q;
  assign sw_change = chg_q;
`ifdef KEY_LONG_PRESS_EN
  assign btn_long = long_q;
`else
  assign btn_long = '0;
`endif

  // Debounce: count consecutive disagreeing samples, accept the new level on the last one
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc[i] = (sync2_q[i] != lvl_q[i]) && (cnt_q[i] == DB_MAX);
      cnt_d[i] = (sync2_q[i] == lvl_q[i] || acc[i]) ? '0 : cnt_q[i] + 1'b1;
      lvl_d[i] = acc[i] ? sync2_q[i] : lvl_q[i];
    end
  end

  // Per-button press FSM driven by accepted transitions
  always_comb begin
    for (int b = 0; b < N_BTN; b++) begin
      st_d[b] = st_q[b];
      press_d[b] = 1'b0;
      rel_d[b] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_d[b] = 1'b0;
      hold_d[b] = hold_q[b];
`endif
      case (st_q[b])
        IDLE: if (rise[b]) begin
          st_d[b] = HELD;
          press_d[b] = 1'b1;
`ifdef KEY_LONG_PRESS_EN
          hold_d[b] = '0;
`endif
        end
        HELD: begin
          if (fall[b]) begin
            st_d[b] = IDLE;
            rel_d[b] = 1'b1;
          end
`ifdef KEY_LONG_PRESS_EN
          else if (hold_q[b] == H_MAX) begin
            st_d[b] = LONG;
            long_d[b] = 1'b1;
          end
          else hold_d[b] = hold_q[b] + 1'b1;
`endif
        end
`ifdef KEY_LONG_PRESS_EN
        LONG: if (fall[b]) begin
          st_d[b] = IDLE;
          rel_d[b] = 1'b1;
        end
`endif
        default: st_d[b] = IDLE;
      endcase
    end
  end

  // State registers; synchronisers cleared so nothing fires on reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q <= '0;
      press_q <= '0;
      rel_q <= '0;
      chg_q <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      for (int b = 0; b < N_BTN; b++) st_q[b] <= IDLE;
`ifdef KEY_LONG_PRESS_EN
      long_q <= '0;
      for (int b = 0; b < N_BTN; b++) hold_q[b] <= '0;
`endif
    end else begin
      sync1_q <= {sw_in, btn_in};
      sync2_q <= sync1_q;
      lvl_q <= lvl_d;
      press_q <= press_d;
      rel_q <= rel_d;
      chg_q <= chg_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      for (int b = 0; b < N_BTN; b++) st_q[b] <= st_d[b];
`ifdef KEY_LONG_PRESS_EN
      long_q <= long_d;
      for (int b = 0; b < N_BTN; b++) hold_q[b] <= hold_d[b];
`endif
    end
  end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input front end for the bomb-dismantlement game. It synchronises and debounces the two push buttons (BTN1 load/start, BTN6 submit) and the eight slide switches (SW7 arm plus SW[6:0] password). It delivers clean levels and single-cycle event pulses to the control FSM, the password generator and the password checker. Each input has its own two-flop synchroniser, per-bit debounce counter and per-button press FSM, plus optional long-press detection.

## Interface
- N_BTN, 2, number of push-button inputs; bit 0 = BTN1, bit 1 = BTN6
- N_SW, 8, number of slide-switch inputs; bit 7 = SW7
- DB_CYCLES, 20000, consecutive stable synchronised samples required to accept a new level; must be ≥ 2
- LONG_CYCLES, 1000000, cycles a debounced button must stay pressed before btn_long fires; must be > DB_CYCLES
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- btn_in  in  N_BTN  raw buttons, 1 = pressed, asynchronous to clk
- sw_in  in  N_SW  raw switches, 1 = up, asynchronous to clk
- btn_level  out  N_BTN  debounced button level
- btn_press  out  N_BTN  one-cycle pulse on a debounced 0→1 transition
- btn_release  out  N_BTN  one-cycle pulse on a debounced 1→0 transition
- btn_long  out  N_BTN  one-cycle pulse, at most once per hold, after LONG_CYCLES held
- sw_level  out  N_SW  debounced switch level
- sw_change  out  1  one-cycle pulse when any sw_level bit updates

## Operation
- Synchroniser: two flops per input bit, giving s = raw delayed 2 cycles. Reset value 0.
- Debounce, per bit:
  - Holds the accepted level L and a counter C. Counter width is $clog2(DB_CYCLES).
  - If s == L: C ← 0.
  - If s != L and C < DB_CYCLES-1: C ← C+1.
  - If s != L and C == DB_CYCLES-1: L ← s, C ← 0, and the bit's event pulse is raised in that same update.
- Button FSM per bit has states IDLE, HELD, LONG:
  - IDLE→HELD on accepted 1; btn_press = 1 for one cycle.
  - HELD→LONG when the hold counter H reaches LONG_CYCLES-1; btn_long = 1 for one cycle.
  - HELD or LONG→IDLE on accepted 0; btn_release = 1 for one cycle.
  - H clears on entry to HELD and does not count in IDLE or LONG. LONG therefore never re-fires until release.
- Switches have no FSM. sw_change = OR over bits of accepted-level updates in that cycle.
- Bits are fully independent. Simultaneous events on several bits raise their pulses in the same cycle.
- Reset (any time, mid-count included):
  - all synchronisers, L, C and H go to 0; FSMs go to IDLE
  - all outputs are 0
  - no pulse is generated on reset deassertion, even if an input is already held high; that input is accepted normally DB_CYCLES+2 cycles later

## Timing
- A raw change first sampled at edge k gives s changed after edge k+1. The accepted level and pulse appear after edge k+DB_CYCLES+1. Latency is DB_CYCLES+2 edges.
- Pulses are exactly one cycle wide and registered; there are no combinational paths from the inputs to the outputs.
- Glitch of at most DB_CYCLES-1 synchronised cycles: C restarts, no output change, no pulse.
- Bounce during the window restarts the count; the event is taken only after the final stable period.
- btn_long asserts LONG_CYCLES cycles after btn_press.
- If release is accepted in the same cycle H would expire, release wins and no btn_long is raised.

## Configuration
- KEY_LONG_PRESS_EN defined: the LONG state, the H counters and btn_long are implemented as above.
- KEY_LONG_PRESS_EN undefined:
  - the FSM has only IDLE and HELD, and no H counters are synthesised
  - btn_long is tied to 0
  - all other behaviour and timing are unchanged

## Test plan
Bench values: DB_CYCLES=4, LONG_CYCLES=16, KEY_LONG_PRESS_EN defined.
- Reset, then btn_in[0] 0→1 sampled at edge 10 → btn_level[0] and btn_press[0] high after edge 15; press high for one cycle only.
- btn_in[1] high for 3 cycles, then low → no change on btn_level, btn_press or btn_release.
- btn_in[0] bounces 1,0,1,0,1 (1-cycle each), then held → exactly one btn_press[0], 4 stable cycles after the last 0.
- Hold btn_in[0] → btn_long[0] exactly 16 cycles after btn_press[0], and only once over 100 cycles. On release → one btn_release[0], no btn_long.
- sw_in 0x00→0x81 in one cycle → sw_level = 0x81 and a single one-cycle sw_change after 6 edges.
- Hold btn_in[0] = 1, pulse rst mid-count → all outputs 0 during reset. After release, btn_press[0] arrives 6 cycles later.
